// File: rtl/aes_ctr_pkg.sv
// Shared AES-CTR definitions used by the round pipeline, counter generator and output stage.
package aes_ctr_pkg;
  localparam int unsigned AES_BLOCK_BITS = 128;
  typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered buffer carrying {data, last}; the head entry drives the outputs directly.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_space,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_head_data;
  logic             r_head_last;
  logic             r_head_valid;
  logic [WIDTH-1:0] r_tail_data;
  logic             r_tail_last;
  logic             r_tail_valid;
  logic             w_pop;

  assign w_pop   = r_head_valid && i_ready;
  // Full only when the tail is occupied and nothing leaves this cycle.
  assign o_space = !r_tail_valid || i_ready;
  assign o_data  = r_head_data;
  assign o_last  = r_head_last;
  assign o_valid = r_head_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_data  <= '0;
      r_head_last  <= 1'b0;
      r_head_valid <= 1'b0;
      r_tail_data  <= '0;
      r_tail_last  <= 1'b0;
      r_tail_valid <= 1'b0;
    end else if (i_flush) begin
      r_head_valid <= 1'b0;
      r_tail_valid <= 1'b0;
    end else if (r_tail_valid) begin
      if (w_pop) begin
        r_head_data  <= r_tail_data;
        r_head_last  <= r_tail_last;
        r_tail_data  <= i_data;
        r_tail_last  <= i_last;
        r_tail_valid <= i_push;
      end
    end else if (r_head_valid) begin
      if (w_pop && i_push) begin
        r_head_data <= i_data;
        r_head_last <= i_last;
      end else if (w_pop) begin
        r_head_valid <= 1'b0;
      end else if (i_push) begin
        r_tail_data  <= i_data;
        r_tail_last  <= i_last;
        r_tail_valid <= 1'b1;
      end
    end else if (i_push) begin
      r_head_data  <= i_data;
      r_head_last  <= i_last;
      r_head_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_ctr_output_stage.sv
// Final AES-CTR stage: joins plaintext with keystream, XORs to ciphertext, buffers and counts output beats.
module aes_ctr_output_stage
  import aes_ctr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AES_BLOCK_BITS,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] ks_tdata,
  input  logic                  ks_tvalid,
  output logic                  ks_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  packet_count
);

  logic                 r_run;
  logic [CNT_WIDTH-1:0] r_word_count;
  logic [CNT_WIDTH-1:0] r_packet_count;
  logic                 w_space;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;

  // r_run holds both ready outputs low while in reset and for the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  assign w_accept      = w_space && r_run && !flush;
  assign s_axis_tready = ks_tvalid && w_accept;
  assign ks_tready     = s_axis_tvalid && w_accept;
  assign w_push        = s_axis_tvalid && ks_tvalid && w_accept;
  assign w_pop         = m_axis_tvalid && m_axis_tready;

  axis_skid_buffer #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (s_axis_tdata ^ ks_tdata),
    .i_last  (s_axis_tlast),
    .o_space (w_space),
    .o_data  (m_axis_tdata),
    .o_last  (m_axis_tlast),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready)
  );

  // Statistics wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count   <= '0;
      r_packet_count <= '0;
    end else if (flush) begin
      r_word_count   <= '0;
      r_packet_count <= '0;
    end else if (w_pop) begin
      r_word_count <= r_word_count + CNT_WIDTH'(1);
      if (m_axis_tlast) r_packet_count <= r_packet_count + CNT_WIDTH'(1);
    end
  end

  assign word_count   = r_word_count;
  assign packet_count = r_packet_count;

endmodule
